// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the router packet generator:
//               FSM state type, header field positions and the payload LFSR
//               polynomial with its step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_GAP     = 3'd4
  } pkt_gen_state_t;

  // Destination port 3 does not exist on the 1x3 router.
  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  // Header byte layout: {length, address}.
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  // Feedback taps b7, b5, b4, b3 of the Fibonacci payload LFSR.
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  // An all-zero seed would lock the LFSR, so it is replaced by this value.
  localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

  // One LFSR step: shift left, feedback XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] value);
    return {value[6:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : router_lfsr8
// Description : 8-bit Fibonacci LFSR producing payload bytes. A load takes
//               priority over a step; a zero load value is replaced by the
//               non-locking seed.
// Revision    : 1.0 - initial release
// ============================================================================
module router_lfsr8
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_step,
  output logic [7:0] o_value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value: load a new seed or advance by one step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load) begin
      lfsr_d = (i_load_val == 8'h00) ? LFSR_ZERO_SEED : i_load_val;
    end else if (i_step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= LFSR_ZERO_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/router_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : router_pkt_gen
// Description : Packet source for the 1x3 router input port. Emits a header
//               byte {len, addr}, len LFSR payload bytes and a trailing XOR
//               parity byte, honouring the router's busy back-pressure.
//               Optional macro ROUTER_PKT_GEN_ERR_INJ_EN adds the
//               corrupt_parity input that inverts the transmitted parity.
// Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int PKT_CNT_W  = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [1:0]           dest_addr,
  input  logic [5:0]           pld_len,
  input  logic [7:0]           seed,
  input  logic                 busy,
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  input  logic                 corrupt_parity,
`endif
  output logic [7:0]           data_out,
  output logic                 pkt_valid,
  output logic                 tx_active,
  output logic                 done,
  output logic                 cfg_err,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  // Gap counter holds GAP_CYCLES-1 down to 0.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  pkt_gen_state_t       state_q, state_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [PKT_CNT_W-1:0] count_q, count_d;
  logic [5:0]           remain_q, remain_d;
  logic [7:0]           acc_q, acc_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic                 cfg_bad;
  logic                 xfer;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic [7:0]           lfsr_val;
  logic [7:0]           hdr_byte;
  logic [7:0]           parity_mask;

  router_lfsr8 u_lfsr (
    .clock      (clock),
    .resetn     (resetn),
    .i_load     (lfsr_load),
    .i_load_val (seed),
    .i_step     (lfsr_step),
    .o_value    (lfsr_val)
  );

`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
  logic corrupt_q;
  logic corrupt_d;

  // Capture the corruption request together with an accepted start.
  always_comb begin
    corrupt_d = corrupt_q;
    if (lfsr_load) begin
      corrupt_d = corrupt_parity;
    end
  end

  // Corruption flag register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      corrupt_q <= 1'b0;
    end else begin
      corrupt_q <= corrupt_d;
    end
  end

  assign parity_mask = {8{corrupt_q}};
`else
  assign parity_mask = 8'h00;
`endif

  assign cfg_bad = (dest_addr == ADDR_ILLEGAL) || (pld_len == 6'd0);
  assign xfer    = !busy && (state_q == ST_HEADER || state_q == ST_PAYLOAD ||
                             state_q == ST_PARITY);

  // Next-state and next-output logic; every output is held unless a byte
  // transfers, which is how busy stalls the stream.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    count_d   = count_q;
    remain_d  = remain_q;
    acc_d     = acc_q;
    gap_d     = gap_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    hdr_byte  = 8'h00;
    hdr_byte[HDR_LEN_MSB:HDR_LEN_LSB]   = pld_len;
    hdr_byte[HDR_ADDR_MSB:HDR_ADDR_LSB] = dest_addr;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            lfsr_load = 1'b1;
            remain_d  = pld_len;
            data_d    = hdr_byte;
            valid_d   = 1'b1;
            active_d  = 1'b1;
            state_d   = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          acc_d     = data_q;
          data_d    = lfsr_val;
          lfsr_step = 1'b1;
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          acc_d    = acc_q ^ data_q;
          remain_d = remain_q - 6'd1;
          if (remain_q == 6'd1) begin
            data_d  = (acc_q ^ data_q) ^ parity_mask;
            valid_d = 1'b0;
            state_d = ST_PARITY;
          end else begin
            data_d    = lfsr_val;
            lfsr_step = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (xfer) begin
          count_d  = count_q + PKT_CNT_W'(1);
          done_d   = 1'b1;
          active_d = 1'b0;
          data_d   = 8'h00;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, output and counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
      remain_q  <= 6'd0;
      acc_q     <= 8'h00;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      remain_q  <= remain_d;
      acc_q     <= acc_d;
      gap_q     <= gap_d;
    end
  end

  assign data_out  = data_q;
  assign pkt_valid = valid_q;
  assign tx_active = active_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign pkt_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_pkt_gen
// Description : Self-checking bench for router_pkt_gen. A packet model builds
//               the expected byte stream from the header/LFSR/parity rules and
//               is compared with the bytes the DUT actually transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_gen;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       busy = 1'b0;
  logic       corrupt = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] pld_len = 6'd0;
  logic [7:0] seed = 8'd0;

  logic [7:0]  d0_data, d1_data;
  logic        d0_valid, d1_valid, d0_active, d1_active;
  logic        d0_done, d1_done, d0_cfg, d1_cfg;
  logic [15:0] d0_count, d1_count;

  router_pkt_gen #(.GAP_CYCLES(2), .PKT_CNT_W(16)) dut0 (
    .clock(clock), .resetn(resetn), .start(start), .dest_addr(dest_addr),
    .pld_len(pld_len), .seed(seed), .busy(busy),
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    .corrupt_parity(corrupt),
`endif
    .data_out(d0_data), .pkt_valid(d0_valid), .tx_active(d0_active),
    .done(d0_done), .cfg_err(d0_cfg), .pkt_count(d0_count)
  );

  router_pkt_gen #(.GAP_CYCLES(0), .PKT_CNT_W(16)) dut1 (
    .clock(clock), .resetn(resetn), .start(start), .dest_addr(dest_addr),
    .pld_len(pld_len), .seed(seed), .busy(busy),
`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    .corrupt_parity(corrupt),
`endif
    .data_out(d1_data), .pkt_valid(d1_valid), .tx_active(d1_active),
    .done(d1_done), .cfg_err(d1_cfg), .pkt_count(d1_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  typedef struct {
    logic [1:0] a;
    logic [5:0] l;
    logic [7:0] s;
    logic       c;
    int         busy_pct;
    logic       has_exp;
    logic [7:0] hdr;
    logic [7:0] par;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Expected stream: {pkt_valid, byte} for header, payload and parity.
  task automatic build_exp(input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] s, input logic c);
    logic [7:0] b;
    logic [7:0] par;
    exp_q.delete();
    par = 8'(int'(l) * 4 + int'(a));
    exp_q.push_back({1'b1, par});
    b = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({1'b1, b});
      par = par ^ b;
      b = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
    end
    exp_q.push_back({1'b0, c ? ~par : par});
  endtask

  task automatic run_pkt(input vec_t v);
    logic       seen_done;
    logic       held;
    logic [7:0] prev_data;
    logic       prev_valid;
    build_exp(v.a, v.l, v.s, v.c);
    dest_addr = v.a; pld_len = v.l; seed = v.s; corrupt = v.c;
    busy = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("hdr_valid", 32'(d0_valid), 32'd1);
    check("hdr_byte", 32'(d0_data), 32'(exp_q[0][7:0]));
    got_q.delete();
    seen_done = 1'b0; held = 1'b0; prev_data = 8'h00; prev_valid = 1'b0;
    for (int k = 0; k < 600 && !seen_done; k++) begin
      if (held) begin
        check("hold_data", 32'(d0_data), 32'(prev_data));
        check("hold_valid", 32'(d0_valid), 32'(prev_valid));
      end
      busy = ($urandom_range(0, 99) < v.busy_pct);
      held = d0_active && busy;
      prev_data = d0_data; prev_valid = d0_valid;
      if (d0_active && !busy) got_q.push_back({d0_valid, d0_data});
      cycle();
      if (d0_done) seen_done = 1'b1;
    end
    busy = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
    exp_count++;
    check("pkt_count", 32'(d0_count), 32'(exp_count));
    check("pkt_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("pkt_byte", 32'(got_q[i]), 32'(exp_q[i]));
    if (v.has_exp && got_q.size() > 0) begin
      check("tbl_hdr", 32'(got_q[0][7:0]), 32'(v.hdr));
      check("tbl_par", 32'(got_q[got_q.size()-1][7:0]), 32'(v.par));
    end
    cycle();
    check("done_one_cycle", 32'(d0_done), 32'd0);
    cycle();
    cycle();
  endtask

  initial begin
    int par0, hdr0, par1, hdr1;
    vec_t v;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_data", 32'(d0_data), 32'd0);
    check("rst_valid", 32'(d0_valid), 32'd0);
    check("rst_active", 32'(d0_active), 32'd0);
    check("rst_done", 32'(d0_done), 32'd0);
    check("rst_cfg_err", 32'(d0_cfg), 32'd0);
    check("rst_count", 32'(d0_count), 32'd0);
    resetn = 1'b1;
    cycle();

    // Vector table
    vecs.push_back('{2'd1, 6'd1,  8'hA5, 1'b0, 0,  1'b1, 8'h05, 8'hA0});
    vecs.push_back('{2'd1, 6'd2,  8'hA5, 1'b0, 0,  1'b1, 8'h09, 8'hE6});
    vecs.push_back('{2'd2, 6'd1,  8'h00, 1'b0, 0,  1'b1, 8'h06, 8'h07});
    vecs.push_back('{2'd2, 6'd63, 8'h3C, 1'b0, 40, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{2'd0, 6'd5,  8'hFF, 1'b0, 50, 1'b0, 8'h00, 8'h00});
    foreach (vecs[i]) run_pkt(vecs[i]);

    // Back-pressure while the first payload byte is presented
    dest_addr = 2'd1; pld_len = 6'd2; seed = 8'hA5; corrupt = 1'b0;
    busy = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("bp_hdr", 32'(d0_data), 32'h09);
    cycle();
    check("bp_a5_first", 32'(d0_data), 32'hA5);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_a5_held", 32'(d0_data), 32'hA5);
      check("bp_valid_held", 32'(d0_valid), 32'd1);
    end
    busy = 1'b0;
    cycle();
    check("bp_next", 32'(d0_data), 32'h4A);
    cycle();
    check("bp_parity", 32'(d0_data), 32'hE6);
    check("bp_parity_valid", 32'(d0_valid), 32'd0);
    cycle();
    check("bp_done", 32'(d0_done), 32'd1);
    exp_count++;
    check("bp_count", 32'(d0_count), 32'(exp_count));
    repeat (3) cycle();

    // Illegal configurations
    dest_addr = 2'd3; pld_len = 6'd4; start = 1'b1;
    cycle();
    start = 1'b0;
    check("cfg_addr_err", 32'(d0_cfg), 32'd1);
    check("cfg_addr_valid", 32'(d0_valid), 32'd0);
    check("cfg_addr_active", 32'(d0_active), 32'd0);
    cycle();
    check("cfg_addr_pulse", 32'(d0_cfg), 32'd0);
    dest_addr = 2'd0; pld_len = 6'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    check("cfg_len_err", 32'(d0_cfg), 32'd1);
    check("cfg_len_valid", 32'(d0_valid), 32'd0);
    cycle();
    check("cfg_len_pulse", 32'(d0_cfg), 32'd0);
    check("cfg_count", 32'(d0_count), 32'(exp_count));

    // Asynchronous reset in the middle of the payload
    dest_addr = 2'd0; pld_len = 6'd10; seed = 8'h5A; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    check("mid_active", 32'(d0_active), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_data", 32'(d0_data), 32'd0);
    check("arst_valid", 32'(d0_valid), 32'd0);
    check("arst_active", 32'(d0_active), 32'd0);
    check("arst_count", 32'(d0_count), 32'd0);
    cycle();
    resetn = 1'b1;
    exp_count = 0;
    cycle();
    v = '{2'd0, 6'd10, 8'h5A, 1'b0, 20, 1'b0, 8'h00, 8'h00};
    run_pkt(v);

`ifdef ROUTER_PKT_GEN_ERR_INJ_EN
    v = '{2'd1, 6'd1, 8'hA5, 1'b1, 0, 1'b1, 8'h05, 8'h5F};
    run_pkt(v);
    v = '{2'd1, 6'd1, 8'hA5, 1'b0, 0, 1'b1, 8'h05, 8'hA0};
    run_pkt(v);
`endif

    // Randomized legal packets
    for (int i = 0; i < 6; i++) begin
      v.a = 2'($urandom_range(0, 2));
      v.l = 6'($urandom_range(1, 63));
      v.s = 8'($urandom);
      v.c = 1'b0;
      v.busy_pct = 30;
      v.has_exp = 1'b0;
      v.hdr = 8'h00;
      v.par = 8'h00;
      run_pkt(v);
    end

    // Back-to-back with start held high: GAP_CYCLES=2 and GAP_CYCLES=0
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();
    dest_addr = 2'd1; pld_len = 6'd1; seed = 8'hA5; busy = 1'b0; start = 1'b1;
    par0 = -1; hdr0 = -1; par1 = -1; hdr1 = -1;
    for (int w = 0; w < 30; w++) begin
      cycle();
      if (par0 < 0 && d0_active && !d0_valid) par0 = w;
      else if (par0 >= 0 && hdr0 < 0 && d0_valid) hdr0 = w;
      if (par1 < 0 && d1_active && !d1_valid) par1 = w;
      else if (par1 >= 0 && hdr1 < 0 && d1_valid) hdr1 = w;
    end
    start = 1'b0;
    check("b2b_gap2", 32'(hdr0 - par0), 32'd4);
    check("b2b_gap0", 32'(hdr1 - par1), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_pkt_gen.md
# router_pkt_gen

- Packet source for the 1x3 router input port.
- Builds one packet per `start`:
  - header byte: `{length[5:0], addr[1:0]}`;
  - LFSR-generated payload bytes;
  - trailing parity byte, the XOR of header and all payload bytes.
- Drives the router's `data_in`/`pkt_valid` and honours its `busy` back-pressure. It is the transmit end of the protocol the router's register/parity-check logic receives.
- Used as the stimulus front end in system benches and as an on-chip traffic source.

## Interface
- `GAP_CYCLES`, default 2: idle cycles enforced after each parity byte before the next `start` is accepted (0 allowed).
- `PKT_CNT_W`, default 16: width of `pkt_count`.

- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request one packet. Sampled only in IDLE.
- `dest_addr` in 2: destination port, 0..2. Value 3 is illegal.
- `pld_len` in 6: payload byte count, 1..63. Value 0 is illegal.
- `seed` in 8: first payload byte / LFSR seed. Sampled with `start`.
- `busy` in 1: router back-pressure. While high, no byte is transferred.
- `data_out` out 8: byte to router `data_in`.
- `pkt_valid` out 1: high for header and payload bytes, low for the parity byte and when idle.
- `tx_active` out 1: high from header through parity, inclusive.
- `done` out 1: one-cycle pulse after the parity byte transfers.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected for illegal `dest_addr` or `pld_len`.
- `pkt_count` out PKT_CNT_W: packets completed, wraps modulo 2^PKT_CNT_W.

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- Transfer rule: the byte on `data_out` is consumed at a rising edge where `busy`=0 and state ∈ {HEADER, PAYLOAD, PARITY}.
- IDLE:
  - `start`=1 with legal config: latch `dest_addr`, `pld_len`, `seed`; go to HEADER.
  - `start`=1 with `dest_addr`=3 or `pld_len`=0: pulse `cfg_err`, stay in IDLE, emit nothing.
  - `busy` is ignored in IDLE.
- HEADER: `data_out`={len,addr}, `pkt_valid`=1. Parity accumulator is loaded with the header byte on transfer. Next state PAYLOAD.
- PAYLOAD:
  - First byte = latched seed (seed 0 is replaced by 8'h01).
  - Each following byte = LFSR step of the previous byte: Fibonacci, shift left, new bit0 = b7^b5^b4^b3.
  - Each transferred byte is XORed into the accumulator. A 6-bit down-counter counts bytes.
  - After the `pld_len`-th transfer, go to PARITY.
- PARITY: `data_out`=accumulator, `pkt_valid`=0. On transfer: `pkt_count`+1, pulse `done`, go to GAP.
- GAP: hold for GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, go straight to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Outputs hold their values while `busy`=1.

## Timing
- Reset values: `data_out`=8'h00, `pkt_valid`=0, `tx_active`=0, `done`=0, `cfg_err`=0, `pkt_count`=0, state IDLE.
- `resetn` low mid-packet clears everything immediately and asynchronously. No parity byte is sent; the router sees the packet truncated.
- All outputs are registered.
- `start` high at edge N: header is on `data_out` with `pkt_valid`=1 after edge N.
- With `busy` held 0, a packet occupies exactly pld_len+2 cycles.
- `done` is high for the one cycle after the parity-transfer edge.
- `cfg_err` is high for the one cycle after the rejecting edge.
- With `busy` held 0 and GAP_CYCLES=G, the earliest next `start` is accepted G+1 cycles after the parity-transfer edge: 1 cycle for the GAP→IDLE transition plus G gap cycles.
- `busy` rising in the same cycle a byte is presented: that byte is held, not skipped or duplicated.
- `pkt_count` wraps from all-ones to 0 without a flag.

## Configuration
- `ROUTER_PKT_GEN_ERR_INJ_EN` defined:
  - adds input `corrupt_parity` (1 bit), sampled with `start`;
  - when latched high, the parity byte sent is the bitwise inverse of the true parity;
  - everything else is unchanged.
- Not defined: the port is absent and parity is always correct.

## Structure
- Shared package `router_pkg` holds:
  - state enum `pkt_gen_state_t`;
  - `ADDR_ILLEGAL`=2'b11;
  - header field positions (addr [1:0], len [7:2]);
  - `LFSR_TAPS`;
  - `LFSR_ZERO_SEED`=8'h01.
- One sub-module: `router_lfsr8`, the 8-bit payload LFSR with load/step enables.
- Counters and the parity accumulator stay in the top level.

## Test plan
- Basic packet: `dest_addr`=1, `pld_len`=1, `seed`=8'hA5, `busy`=0.
  - `data_out` = 8'h05, 8'hA5, 8'hA0.
  - `pkt_valid` = 1, 1, 0.
  - `done` pulses and `pkt_count`=1.
- Two-byte payload: `dest_addr`=1, `pld_len`=2, `seed`=8'hA5.
  - Bytes 8'h09, 8'hA5, 8'h4A, parity 8'hE6.
- Back-pressure: same packet, `busy`=1 for 3 cycles while 8'hA5 is presented.
  - 8'hA5 is held for 4 cycles, then the sequence continues unchanged.
- Illegal config:
  - `dest_addr`=3 → `cfg_err` pulse, `pkt_valid` stays 0.
  - `pld_len`=0 → same response.
- Reset mid-payload (`pld_len`=10, reset after 4th byte):
  - all outputs 0 asynchronously;
  - the next legal `start` produces a correct fresh packet.
- `ROUTER_PKT_GEN_ERR_INJ_EN` with `corrupt_parity`=1 on the basic packet → parity byte 8'h5F.
- Back-to-back:
  - GAP_CYCLES=2, `start` held high: next header appears exactly 4 cycles after the parity byte.
  - GAP_CYCLES=0: the gap is exactly 2 cycles.
